alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu.sv | 78 +++++++
 tb/tb_alu.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// alu: 16-bit ALU with combinational result/flags and registered copies.
module alu (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic [3:0]  alu_op,
   output logic [15:0] result,
   output logic        zero,
   output logic        carry,
   output logic        overflow,
   output logic        negative,
   output logic [15:0] result_q,
   output logic [3:0]  flags_q
);
   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_SLT  = 4'h4;
   localparam logic [3:0] OP_SLL  = 4'h5;
   localparam logic [3:0] OP_SRL  = 4'h6;
   localparam logic [3:0] OP_XOR  = 4'h7;
   localparam logic [3:0] OP_NOR  = 4'h8;
   localparam logic [3:0] OP_SRA  = 4'h9;
   localparam logic [3:0] OP_SLTU = 4'hA;
   logic [16:0] sum;
   logic [16:0] diff;
   logic        no_borrow;
   assign sum       = {1'b0, a} + {1'b0, b};
   assign diff      = {1'b0, a} - {1'b0, b};
   assign no_borrow = ~diff[16];
   // Compares share the subtractor so carry reports NOT borrow of a-b.
   always_comb begin
      result   = '0;
      carry    = 1'b0;
      overflow = 1'b0;
      case (alu_op)
         OP_ADD: begin
            result   = sum[15:0];
            carry    = sum[16];
            overflow = (a[15] == b[15]) && (sum[15] != a[15]);
         end
         OP_SUB: begin
            result   = diff[15:0];
            carry    = no_borrow;
            overflow = (a[15] != b[15]) && (diff[15] != a[15]);
         end
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_NOR:  result = ~(a | b);
         OP_SLT: begin
            result = {15'b0, $signed(a) < $signed(b)};
            carry  = no_borrow;
         end
         OP_SLTU: begin
            result = {15'b0, diff[16]};
            carry  = no_borrow;
         end
         OP_SLL:  result = b << a[3:0];
         OP_SRL:  result = b >> a[3:0];
         OP_SRA:  result = $signed(b) >>> a[3:0];
         default: result = '0;
      endcase
   end
   assign zero     = result == 16'h0000;
   assign negative = result[15];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         result_q <= result;
         flags_q  <= {negative, overflow, carry, zero};
      end
   end
endmodule

// File: tb/tb_alu.sv
// tb_alu: randomized scoreboard bench for alu against an arithmetic reference model.
module tb_alu;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic [3:0]  alu_op = '0;
   logic [15:0] result;
   logic        zero;
   logic        carry;
   logic        overflow;
   logic        negative;
   logic [15:0] result_q;
   logic [3:0]  flags_q;

   alu dut (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .alu_op(alu_op),
      .result(result), .zero(zero), .carry(carry), .overflow(overflow),
      .negative(negative), .result_q(result_q), .flags_q(flags_q)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] r;
      logic        n;
      logic        v;
      logic        c;
      logic        z;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (op=%0h a=%h b=%h)", name, act, req, alu_op, a, b);
      end
   endtask

   // Reference model works on integer values, not on bit-level structure.
   function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic [3:0] op);
      exp_t   e;
      int     sx = $signed(x);
      int     sy = $signed(y);
      longint ux = x;
      longint uy = y;
      int     sh = int'(x) % 16;
      longint p = longint'(1) << sh;
      longint qq;
      e = '0;
      case (op)
         4'h0: begin
            e.r = 16'((ux + uy) % 65536);
            e.c = (ux + uy) > 65535;
            e.v = (sx + sy) > 32767 || (sx + sy) < -32768;
         end
         4'h1: begin
            e.r = 16'((ux - uy + 65536) % 65536);
            e.c = ux >= uy;
            e.v = (sx - sy) > 32767 || (sx - sy) < -32768;
         end
         4'h2: e.r = x & y;
         4'h3: e.r = x | y;
         4'h7: e.r = x ^ y;
         4'h8: e.r = ~(x | y);
         4'h4: begin
            e.r = (sx < sy) ? 16'd1 : 16'd0;
            e.c = ux >= uy;
         end
         4'hA: begin
            e.r = (ux < uy) ? 16'd1 : 16'd0;
            e.c = ux >= uy;
         end
         4'h5: e.r = 16'((uy * p) % 65536);
         4'h6: e.r = 16'(uy / p);
         4'h9: begin
            qq = sy / p;
            if (sy < 0 && (sy % p) != 0) qq = qq - 1;
            e.r = 16'(qq);
         end
         default: e.r = '0;
      endcase
      e.z = e.r == 16'h0000;
      e.n = e.r[15];
      return e;
   endfunction

   task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic [3:0] op);
      @(negedge clk);
      a = x;
      b = y;
      alu_op = op;
      q.push_back(model(x, y, op));
   endtask

   // Monitor: inputs only change on negedge, so at posedge+1 both the
   // combinational outputs and the freshly captured registers match one entry.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n && q.size() > 0) begin
            e = q.pop_front();
            chk("result", result, e.r);
            chk("zero", zero, e.z);
            chk("carry", carry, e.c);
            chk("overflow", overflow, e.v);
            chk("negative", negative, e.n);
            chk("result_q", result_q, e.r);
            chk("flags_q", flags_q, {e.n, e.v, e.c, e.z});
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   function automatic logic [15:0] pick();
      logic [15:0] corners [5] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
      return ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 16'($urandom);
   endfunction

   initial begin
      a = 16'd5;
      b = 16'd3;
      alu_op = 4'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_result_q", result_q, 16'h0000);
      chk("reset_flags_q", flags_q, 4'h0);
      chk("reset_comb_result", result, 16'h0008);
      @(negedge clk);
      rst_n = 1'b1;
      drive(16'h0005, 16'h0003, 4'h0);
      drive(16'hFFFF, 16'h0001, 4'h0);
      drive(16'h7FFF, 16'h0001, 4'h0);
      drive(16'h0005, 16'h0003, 4'h1);
      drive(16'h0003, 16'h0003, 4'h1);
      drive(16'h8000, 16'h0001, 4'h1);
      drive(16'hFF00, 16'h0F0F, 4'h2);
      drive(16'hFF00, 16'h0F0F, 4'h3);
      drive(16'hFF00, 16'h0F0F, 4'h7);
      drive(16'h0000, 16'h0000, 4'h8);
      drive(16'd5, 16'd10, 4'h4);
      drive(16'd10, 16'd5, 4'h4);
      drive(16'hFFFF, 16'h0001, 4'h4);
      drive(16'hFFFF, 16'h0001, 4'hA);
      drive(16'd2, 16'd1, 4'h5);
      drive(16'd2, 16'd8, 4'h6);
      drive(16'd4, 16'h8000, 4'h9);
      drive(16'h0012, 16'd1, 4'h5);
      drive(16'hFFF0, 16'hA5C3, 4'h5);
      drive(16'h0000, 16'h8001, 4'h6);
      drive(16'h1234, 16'hBEEF, 4'hB);
      drive(16'hFFFF, 16'hFFFF, 4'hF);
      for (int i = 0; i < 400; i++) drive(pick(), pick(), 4'($urandom_range(0, 15)));
      drive(16'h0005, 16'h0003, 4'h0);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("midreset_result_q", result_q, 16'h0000);
      chk("midreset_flags_q", flags_q, 4'h0);
      chk("midreset_comb_result", result, 16'h0008);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 50; i++) drive(pick(), pick(), 4'($urandom_range(0, 10)));
      repeat (2) @(posedge clk);
      #2;
      chk("scoreboard_drained", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
